// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmit and receive blocks.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_STABLE_COUNT = 16;
  localparam int unsigned UART_BAUD_PERIOD  = 868;

  localparam int unsigned S_IDLE_IDX  = 0;
  localparam int unsigned S_START_IDX = 1;
  localparam int unsigned S_DATA_IDX  = 2;
  localparam int unsigned S_STOP_IDX  = 3;
  localparam int unsigned S_BREAK_IDX = 4;

  typedef enum logic [4:0] {
    S_IDLE  = 5'(1 << S_IDLE_IDX),
    S_START = 5'(1 << S_START_IDX),
    S_DATA  = 5'(1 << S_DATA_IDX),
    S_STOP  = 5'(1 << S_STOP_IDX),
    S_BREAK = 5'(1 << S_BREAK_IDX)
  } rx_state_e;

endpackage

// File: rtl/uart_rx_filter.sv
// Two-flop synchronizer followed by a registered 3-sample majority vote on the serial line.
module uart_rx_filter (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_reset,
  input  logic rxd,
  output logic rxd_f
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;
  logic       rxd_f_q;
  logic       maj;

  assign maj = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  // Everything presets high so reset looks like an idle line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      hist_q  <= 3'b111;
      rxd_f_q <= 1'b1;
    end else if (sync_reset) begin
      sync_q  <= 2'b11;
      hist_q  <= 3'b111;
      rxd_f_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      hist_q  <= {hist_q[1:0], sync_q[1]};
      rxd_f_q <= maj;
    end
  end

  assign rxd_f = rxd_f_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: filtered line, one-hot frame FSM, sticky valid/overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned STABLE_TIME      = UART_STABLE_COUNT,
  parameter int unsigned BAUD_PERIOD_BITS = $clog2(UART_BAUD_PERIOD)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sync_reset,
  input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
  input  logic                        RXD,
  input  logic                        rx_ack,
  output logic [UART_DATA_BITS-1:0]   SBUF_out,
  output logic                        rx_valid,
  output logic                        overrun_err,
  output logic                        frame_err,
  output logic                        rx_active
);

  localparam int unsigned StableW = $clog2(STABLE_TIME + 1);
  localparam logic [StableW-1:0] StableMax = StableW'(STABLE_TIME);
  localparam logic [3:0] LastBit = 4'(UART_DATA_BITS - 1);

  rx_state_e                   state_q, state_d;
  logic [BAUD_PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [BAUD_PERIOD_BITS-1:0] period_q, period_d;
  logic [StableW-1:0]          stable_q, stable_d;
  logic [3:0]                  bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_DATA_BITS-1:0]   sbuf_q;
  logic                        rx_valid_q, overrun_q, frame_err_q;
  logic                        rxd_f, done, bad_stop;

  uart_rx_filter u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .rxd        (RXD),
    .rxd_f      (rxd_f)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done      = 1'b0;
    bad_stop  = 1'b0;
    // Idle-line qualifier saturates; any low sample restarts it.
    if (!rxd_f)                  stable_d = '0;
    else if (stable_q != StableMax) stable_d = stable_q + 1'b1;
    else                         stable_d = stable_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (stable_q == StableMax && !rxd_f) begin
          state_d   = S_START;
          period_d  = baud_rate_period_m1;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (cnt_q == (period_q >> 1)) begin
          cnt_d   = '0;
          state_d = rxd_f ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == period_q) begin
          cnt_d     = '0;
          shift_d   = {rxd_f, shift_q[UART_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == period_q) begin
          cnt_d = '0;
          if (rxd_f) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rxd_f) begin
          state_d  = S_IDLE;
          stable_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      stable_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sbuf_q      <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (sync_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      stable_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sbuf_q      <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      stable_q    <= stable_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= bad_stop;
      // A completing byte beats a simultaneous ack; without ack it overruns a pending byte.
      if (done) begin
        sbuf_q     <= shift_q;
        rx_valid_q <= 1'b1;
        overrun_q  <= rx_ack ? 1'b0 : (overrun_q | rx_valid_q);
      end else if (rx_ack) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
    end
  end

  assign SBUF_out    = sbuf_q;
  assign rx_valid    = rx_valid_q;
  assign overrun_err = overrun_q;
  assign frame_err   = frame_err_q;
  assign rx_active   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, overrun, framing error/break, glitch, resets, spike.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned BPB = $clog2(UART_BAUD_PERIOD);
  localparam int unsigned M1  = 15;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           sync_reset = 1'b0;
  logic [BPB-1:0] baud_rate_period_m1 = BPB'(M1);
  logic           RXD = 1'b1;
  logic           rx_ack = 1'b0;
  logic [7:0]     SBUF_out;
  logic           rx_valid, overrun_err, frame_err, rx_active;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int act_rise = 0;
  logic act_prev = 1'b0;
  int fe0, act0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .sync_reset          (sync_reset),
    .baud_rate_period_m1 (baud_rate_period_m1),
    .RXD                 (RXD),
    .rx_ack              (rx_ack),
    .SBUF_out            (SBUF_out),
    .rx_valid            (rx_valid),
    .overrun_err         (overrun_err),
    .frame_err           (frame_err),
    .rx_active           (rx_active)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (rx_active && !act_prev) act_rise++;
    act_prev = rx_active;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    RXD = b;
    clks(M1 + 1);
  endtask

  // spike_bit selects a data bit that gets a one-clock inverted pulse at mid-bit (-1: none).
  task automatic send_byte(input logic [7:0] d, input logic stop, input int spike_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == spike_bit) begin
        RXD = d[i];
        clks(8);
        RXD = ~d[i];
        clks(1);
        RXD = d[i];
        clks(7);
      end else begin
        send_bit(d[i]);
      end
    end
    send_bit(stop);
    RXD = 1'b1;
  endtask

  task automatic ack;
    rx_ack = 1'b1;
    clks(1);
    rx_ack = 1'b0;
    clks(1);
  endtask

  initial begin
    clks(3);
    check("rst_sbuf", SBUF_out, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_overrun", overrun_err, 1'b0);
    check("rst_frame", frame_err, 1'b0);
    check("rst_active", rx_active, 1'b0);
    reset_n = 1'b1;
    clks(40);

    // Clean 0xA5 frame.
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b1, -1);
    check("a5_sbuf", SBUF_out, 8'hA5);
    check("a5_valid", rx_valid, 1'b1);
    check("a5_overrun", overrun_err, 1'b0);
    check("a5_active", rx_active, 1'b0);
    check("a5_no_frame_err", fe_cnt - fe0, 0);
    ack();
    check("a5_ack_valid", rx_valid, 1'b0);
    clks(48);

    // Overrun: two bytes with no ack.
    send_byte(8'h3C, 1'b1, -1);
    clks(48);
    send_byte(8'hC3, 1'b1, -1);
    clks(2);
    check("ovr_sbuf", SBUF_out, 8'hC3);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_overrun", overrun_err, 1'b1);
    ack();
    check("ovr_ack_valid", rx_valid, 1'b0);
    check("ovr_ack_overrun", overrun_err, 1'b0);
    check("ovr_ack_sbuf", SBUF_out, 8'hC3);
    clks(48);

    // Bad stop bit, then line held low 20 bit times.
    fe0 = fe_cnt;
    act0 = act_rise;
    send_byte(8'h55, 1'b0, -1);
    RXD = 1'b0;
    clks(20 * (M1 + 1));
    check("brk_frame_pulses", fe_cnt - fe0, 1);
    check("brk_valid", rx_valid, 1'b0);
    check("brk_sbuf", SBUF_out, 8'hC3);
    check("brk_active", rx_active, 1'b1);
    check("brk_one_start", act_rise - act0, 1);
    RXD = 1'b1;
    clks(16);
    check("brk_exit_active", rx_active, 1'b0);
    clks(48);

    // 4-clock low glitch is a false start.
    fe0 = fe_cnt;
    act0 = act_rise;
    RXD = 1'b0;
    clks(4);
    RXD = 1'b1;
    clks(40);
    check("glitch_started", act_rise - act0, 1);
    check("glitch_idle", rx_active, 1'b0);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_no_frame_err", fe_cnt - fe0, 0);
    check("glitch_sbuf", SBUF_out, 8'hC3);
    clks(48);

    // Async reset during data bit 4 of 0xFF.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    clks(8);
    reset_n = 1'b0;
    #1;
    check("midrst_sbuf", SBUF_out, 8'h00);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_overrun", overrun_err, 1'b0);
    check("midrst_frame", frame_err, 1'b0);
    check("midrst_active", rx_active, 1'b0);
    clks(2);
    reset_n = 1'b1;
    clks(48);
    send_byte(8'h81, 1'b1, -1);
    check("post_rst_sbuf", SBUF_out, 8'h81);
    check("post_rst_valid", rx_valid, 1'b1);
    check("post_rst_overrun", overrun_err, 1'b0);
    ack();
    clks(48);

    // Single-clock spike on bit 2 of 0x00 is filtered out.
    send_byte(8'h00, 1'b1, 2);
    check("spike_sbuf", SBUF_out, 8'h00);
    check("spike_valid", rx_valid, 1'b1);

    // Synchronous soft reset clears the flags and buffer.
    sync_reset = 1'b1;
    clks(1);
    sync_reset = 1'b0;
    check("srst_valid", rx_valid, 1'b0);
    check("srst_active", rx_active, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
